// File: rtl/vec_mac_host_ctrl.sv
// vec_mac_host_ctrl: drives a pin-level MAC device to load LANES weight/activation pairs and read back the 3-byte sum.
module vec_mac_host_ctrl #(
  parameter int LANES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [8*LANES-1:0] cmd_w,
  input  logic [8*LANES-1:0] cmd_a,
  input  logic [3:0]         cmd_len,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [18:0]        res_data,
  output logic               res_hi_err,
  output logic               busy,
  output logic [7:0]         pin_ui,
  output logic [7:0]         pin_uio,
  input  logic [7:0]         pin_uo
);
  typedef enum logic [3:0] {IDLE, LDW, LDA, READ, GAP, CAP2, CAP1, CAP0, DONE} state_t;
  localparam logic [3:0] LMAX = 4'(LANES);
  state_t state, nstate;
  logic [3:0] cnt, ncnt, len_q, len_eff, len_src;
  logic [8*LANES-1:0] w_q, a_q, w_src, a_src;
  logic [7:0] b2, b1, b0, n_ui, n_uio, w_byte, a_byte;
  logic accept, last;
  assign cmd_ready  = state == IDLE;
  assign busy       = state != IDLE;
  assign res_valid  = state == DONE;
  assign accept     = cmd_valid && cmd_ready;
  assign last       = cnt == LMAX - 4'd1;
  assign len_eff    = (cmd_len == 4'd0 || cmd_len > LMAX) ? LMAX : cmd_len;
  assign res_data   = {b2[2:0], b1, b0};
  assign res_hi_err = |b2[7:3];
  // Pins are registered from next-state values so they line up with the state; the first LDW lane comes straight from the command.
  assign w_src   = accept ? cmd_w : w_q;
  assign a_src   = accept ? cmd_a : a_q;
  assign len_src = accept ? len_eff : len_q;
  assign w_byte  = w_src[8*int'(ncnt) +: 8];
  assign a_byte  = a_src[8*int'(ncnt) +: 8];
  always_comb begin
    nstate = state;
    ncnt   = cnt;
    unique case (state)
      IDLE: if (accept) begin
        nstate = LDW;
        ncnt   = 4'd0;
      end
      LDW: begin
        nstate = last ? LDA : LDW;
        ncnt   = last ? 4'd0 : cnt + 4'd1;
      end
      LDA: begin
        nstate = last ? READ : LDA;
        ncnt   = last ? 4'd0 : cnt + 4'd1;
      end
      READ: nstate = GAP;
      GAP:  nstate = CAP2;
      CAP2: nstate = CAP1;
      CAP1: nstate = CAP0;
      CAP0: nstate = DONE;
      DONE: nstate = res_ready ? IDLE : DONE;
      default: nstate = IDLE;
    endcase
    n_ui  = nstate == LDW  ? {2'b00, 2'b00, ncnt} :
            nstate == LDA  ? {2'b01, 2'b00, ncnt} :
            nstate == READ ? 8'h80 : 8'hC0;
    n_uio = ((nstate == LDW || nstate == LDA) && ncnt < len_src) ?
            (nstate == LDW ? w_byte : a_byte) : 8'h00;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      b2      <= 8'h00;
      b1      <= 8'h00;
      b0      <= 8'h00;
      pin_ui  <= 8'hC0;
      pin_uio <= 8'h00;
    end else begin
      state   <= nstate;
      cnt     <= ncnt;
      pin_ui  <= n_ui;
      pin_uio <= n_uio;
      if (accept) begin
        w_q   <= cmd_w;
        a_q   <= cmd_a;
        len_q <= len_eff;
      end
      if (state == CAP2) b2 <= pin_uo;
      if (state == CAP1) b1 <= pin_uo;
      if (state == CAP0) b0 <= pin_uo;
    end
  end
endmodule

// File: tb/tb_vec_mac_host_ctrl.sv
// tb_vec_mac_host_ctrl: directed checks of the host controller against a behavioural MAC device.
module tb_vec_mac_host_ctrl;
  localparam int L = 8;
  logic clk = 0, rst = 1, cmd_valid = 0, res_ready = 0;
  logic [8*L-1:0] cmd_w = '0, cmd_a = '0;
  logic [3:0] cmd_len = 0;
  logic cmd_ready, res_valid, res_hi_err, busy;
  logic [18:0] res_data;
  logic [7:0] pin_ui, pin_uio, pin_uo;
  int n_chk = 0, n_fail = 0;
  int rd_cnt = 0, bad_cnt = 0, cur_len = 8;
  logic force_top = 0;
  logic [7:0] dev_w [L];
  logic [7:0] dev_a [L];
  logic [23:0] sreg;
  int ph = 0;
  logic [7:0] uo_q = 0;

  vec_mac_host_ctrl #(.LANES(L)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_w(cmd_w), .cmd_a(cmd_a), .cmd_len(cmd_len), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_hi_err(res_hi_err),
    .busy(busy), .pin_ui(pin_ui), .pin_uio(pin_uio), .pin_uo(pin_uo)
  );

  always #5 clk = ~clk;
  assign pin_uo = uo_q;

  function automatic logic [23:0] dev_sum();
    logic [23:0] s = 0;
    for (int i = 0; i < L; i++) s += 24'(dev_w[i]) * 24'(dev_a[i]);
    return s;
  endfunction

  // Device: MAC registers, sum latched on READ_S, bytes presented high-first on following cycles.
  always @(posedge clk) begin
    ph <= (ph == 0 || ph == 3) ? 0 : ph + 1;
    if (ph == 1) uo_q <= force_top ? 8'h1F : sreg[23:16];
    if (ph == 2) uo_q <= sreg[15:8];
    if (ph == 3) uo_q <= sreg[7:0];
    case (pin_ui[7:6])
      2'b00: dev_w[pin_ui[2:0]] <= pin_uio;
      2'b01: dev_a[pin_ui[2:0]] <= pin_uio;
      2'b10: begin
        sreg   <= dev_sum();
        ph     <= 1;
        rd_cnt <= rd_cnt + 1;
      end
      default: ;
    endcase
    if (pin_ui[7] == 1'b0 && int'(pin_ui[5:0]) >= cur_len && pin_uio != 8'h00) bad_cnt <= bad_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input string tag, input logic [7:0] wb, input logic [7:0] ab,
                         input logic [3:0] len, input int hold, input bit ack,
                         input logic [18:0] exp_data, input logic exp_err);
    int lat = 0, rd0;
    bit busy_bad = 0, hold_bad = 0;
    logic [18:0] d0;
    @(negedge clk);
    cur_len = (len == 0 || len > 8) ? 8 : int'(len);
    rd0 = rd_cnt;
    cmd_w = {L{wb}};
    cmd_a = {L{ab}};
    cmd_len = len;
    cmd_valid = 1;
    @(posedge clk);
    #1;
    cmd_w = {$urandom, $urandom};
    cmd_a = {$urandom, $urandom};
    cmd_len = 4'($urandom);
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (res_valid === 1'b1) begin
        lat = i;
        break;
      end
      if (cmd_ready !== 1'b0 || busy !== 1'b1) busy_bad = 1;
    end
    cmd_valid = 0;
    chk({tag, "_latency"}, lat, 21);
    chk({tag, "_busy_not_ready"}, busy_bad, 0);
    chk({tag, "_data"}, res_data, exp_data);
    chk({tag, "_hi_err"}, res_hi_err, exp_err);
    chk({tag, "_one_read"}, rd_cnt - rd0, 1);
    chk({tag, "_zero_lanes"}, bad_cnt, 0);
    d0 = res_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (res_data !== d0 || res_valid !== 1'b1 || cmd_ready !== 1'b0) hold_bad = 1;
    end
    if (hold > 0) chk({tag, "_hold_stable"}, hold_bad, 0);
    if (ack) begin
      res_ready = 1;
      @(posedge clk);
      #1;
      res_ready = 0;
      chk({tag, "_idle_after_ack"}, {res_valid, busy, cmd_ready}, 3'b001);
    end
  endtask

  initial begin
    int rd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    chk("reset_flags", {cmd_ready, busy, res_valid, res_hi_err}, 4'b1000);
    chk("reset_data", res_data, 0);
    chk("reset_pins", {pin_ui, pin_uio}, 16'hC000);
    run_cmd("w2a3", 8'd2, 8'd3, 4'd8, 0, 1, 19'd48, 1'b0);
    run_cmd("max", 8'd255, 8'd255, 4'd8, 5, 1, 19'h7F008, 1'b0);
    run_cmd("len3", 8'd10, 8'd10, 4'd3, 0, 1, 19'd300, 1'b0);
    run_cmd("len0", 8'd1, 8'd5, 4'd0, 0, 1, 19'd40, 1'b0);
    run_cmd("len12", 8'd1, 8'd1, 4'd12, 0, 1, 19'd8, 1'b0);
    force_top = 1;
    run_cmd("hi_err", 8'd1, 8'd1, 4'd8, 0, 0, 19'h70008, 1'b1);
    chk("hi_err_top_bits", res_data[18:16], 3'b111);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    force_top = 0;
    chk("rst_drop_result", {res_valid, res_hi_err, res_data}, 0);
    chk("rst_drop_ready", {busy, cmd_ready}, 2'b01);
    @(negedge clk);
    cmd_w = {L{8'd7}};
    cmd_a = {L{8'd7}};
    cmd_len = 8;
    cur_len = 8;
    cmd_valid = 1;
    @(posedge clk);
    #1;
    cmd_valid = 0;
    repeat (12) @(posedge clk);
    #1;
    chk("lda_lane4_pin", {pin_ui, pin_uio}, 16'h4407);
    rd0 = rd_cnt;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    chk("abort_pins", {pin_ui, pin_uio}, 16'hC000);
    chk("abort_flags", {busy, cmd_ready, res_valid}, 3'b010);
    repeat (30) @(posedge clk);
    #1;
    chk("abort_no_read", rd_cnt - rd0, 0);
    chk("abort_pins_idle", {pin_ui, pin_uio}, 16'hC000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
